// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types and constants for the RV32E multi-cycle sequencer.
//   state_e         - 3-bit sequencer state encoding (StIdle = 0 ... StHalt = 7)
//   EbreakInstDef   - default encoding of the halting ebreak instruction
//   wdog_width()    - bit width needed for a watchdog that counts up to a timeout
package core_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StIwait = 3'd2,
    StExec  = 3'd3,
    StMem   = 3'd4,
    StMwait = 3'd5,
    StWb    = 3'd6,
    StHalt  = 3'd7
  } state_e;

  localparam logic [31:0] EbreakInstDef = 32'h00100073;

  // $clog2(timeout + 1), never narrower than one bit.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/core_seq_wdog.sv
// core_seq_wdog: wait-state watchdog for the sequencer.
// Counts cycles while enabled; clear (or reset) returns it to zero. o_expire is high in the
// cycle that would be the TIMEOUT-th consecutive enabled cycle, so the owner can leave the
// wait state on the following edge.
// Ports:
//   i_clock   in  1  rising-edge clock
//   i_reset   in  1  synchronous active-high reset
//   i_clear   in  1  zero the count (owner is outside any wait state)
//   i_enable  in  1  count this cycle
//   o_expire  out 1  TIMEOUT enabled cycles reached
module core_seq_wdog import core_seq_pkg::*; #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned Width = wdog_width(TIMEOUT);
  localparam logic [Width-1:0] Limit = Width'(TIMEOUT - 1);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign o_expire = i_enable && (r_count == Limit);

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer for the RV32E core.
// Fetches over a valid/ready handshake, latches the instruction, lets the datapath settle
// for one EXEC cycle, optionally performs a load/store handshake, then allows exactly one
// write-back cycle (PC update + gated register write). Halts on ebreak or on a watchdog
// timeout in any wait state. Outputs are decoded from state only, except o_reg_wen.
// Optional feature macro: CORE_SEQ_PERF_EN adds 64-bit cycle and retired-instruction counters.
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   o_ifu_req_valid            fetch request (address is the PC unit's current PC)
//   i_ifu_req_ready            IFU accepts request
//   i_ifu_rsp_valid/_inst      fetched instruction and its valid
//   o_inst                     latched instruction register feeding the IDU
//   i_is_mem                   IDU decode: current instruction is a load/store
//   o_lsu_req_valid            memory access request
//   i_lsu_req_ready            LSU accepts request
//   i_lsu_rsp_valid            LSU access complete
//   i_exu_reg_wen              EXU combinational register write enable
//   o_reg_wen                  gated register-file write enable
//   o_pc_wen                   PC update strobe
//   o_halt, o_halt_err         sticky halt, and halt caused by timeout (0 = ebreak)
//   o_perf_cycles/_insts       (CORE_SEQ_PERF_EN only) non-halted cycles, write-back count
module core_seq_ctrl import core_seq_pkg::*; #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      TIMEOUT     = 1023,
  parameter logic [XLEN-1:0]  EBREAK_INST = XLEN'(EbreakInstDef)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  output logic            o_ifu_req_valid,
  input  logic            i_ifu_req_ready,
  input  logic            i_ifu_rsp_valid,
  input  logic [XLEN-1:0] i_ifu_rsp_inst,
  output logic [XLEN-1:0] o_inst,
  input  logic            i_is_mem,
  output logic            o_lsu_req_valid,
  input  logic            i_lsu_req_ready,
  input  logic            i_lsu_rsp_valid,
  input  logic            i_exu_reg_wen,
  output logic            o_reg_wen,
  output logic            o_pc_wen,
  output logic            o_halt,
  output logic            o_halt_err
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [63:0]     o_perf_cycles,
  output logic [63:0]     o_perf_insts
`endif
);

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_inst;
  logic            r_halt_err;
  logic            w_latch;
  logic            w_set_err;
  logic            w_wait;
  logic            w_expire;

  assign w_wait = (r_state == StFetch) || (r_state == StIwait) ||
                  (r_state == StMem)   || (r_state == StMwait);

  core_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (!w_wait),
    .i_enable (w_wait),
    .o_expire (w_expire)
  );

  // Responses arriving outside their request/wait state fall through to the hold default.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      StIdle: w_state_next = StFetch;
      StFetch: begin
        if (w_expire) begin
          w_state_next = StHalt;
          w_set_err    = 1'b1;
        end else if (i_ifu_req_ready) begin
          if (i_ifu_rsp_valid) begin
            w_latch      = 1'b1;
            w_state_next = StExec;
          end else begin
            w_state_next = StIwait;
          end
        end
      end
      StIwait: begin
        if (w_expire) begin
          w_state_next = StHalt;
          w_set_err    = 1'b1;
        end else if (i_ifu_rsp_valid) begin
          w_latch      = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: begin
        if (r_inst == EBREAK_INST) w_state_next = StHalt;
        else if (i_is_mem)         w_state_next = StMem;
        else                       w_state_next = StWb;
      end
      StMem: begin
        if (w_expire) begin
          w_state_next = StHalt;
          w_set_err    = 1'b1;
        end else if (i_lsu_req_ready) begin
          w_state_next = i_lsu_rsp_valid ? StWb : StMwait;
        end
      end
      StMwait: begin
        if (w_expire) begin
          w_state_next = StHalt;
          w_set_err    = 1'b1;
        end else if (i_lsu_rsp_valid) begin
          w_state_next = StWb;
        end
      end
      StWb:    w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_inst     <= '0;
      r_halt_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_latch)   r_inst     <= i_ifu_rsp_inst;
      if (w_set_err) r_halt_err <= 1'b1;
    end
  end

  assign o_ifu_req_valid = (r_state == StFetch);
  assign o_lsu_req_valid = (r_state == StMem);
  assign o_pc_wen        = (r_state == StWb);
  assign o_reg_wen       = (r_state == StWb) && i_exu_reg_wen;
  assign o_halt          = (r_state == StHalt);
  assign o_halt_err      = r_halt_err;
  assign o_inst          = r_inst;

`ifdef CORE_SEQ_PERF_EN
  logic [63:0] r_perf_cycles;
  logic [63:0] r_perf_insts;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_cycles <= '0;
      r_perf_insts  <= '0;
    end else begin
      if (r_state != StHalt) r_perf_cycles <= r_perf_cycles + 64'd1;
      if (r_state == StWb)   r_perf_insts  <= r_perf_insts + 64'd1;
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_insts  = r_perf_insts;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: watchdog timeout on a TIMEOUT=8 instance, a directed vector table
// (fetch paths, load/store paths, ebreak), halt quiet period, reset during MWAIT, then
// randomized traffic against a transaction-level reference model.
module tb_core_seq_ctrl;

  localparam int unsigned TimeoutMain = 1023;
  localparam int unsigned TimeoutShort = 8;
  localparam logic [31:0] Ebreak = 32'h00100073;
  localparam int NumRandom = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT stimulus / observation
  logic        rst, ir, iv, mem, lr, lv, ew;
  logic [31:0] ri;
  logic        o_irv, o_lrv, o_rw, o_pc, o_h, o_he;
  logic [31:0] o_inst;
  logic [63:0] perf_cyc, perf_ins;

  // short-timeout DUT
  logic        t_rst;
  logic        t_irv, t_lrv, t_rw, t_pc, t_h, t_he;
  logic [31:0] t_inst;
  logic [63:0] t_perf_cyc, t_perf_ins;

  core_seq_ctrl #(
    .TIMEOUT (TimeoutMain)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .o_ifu_req_valid (o_irv),
    .i_ifu_req_ready (ir),
    .i_ifu_rsp_valid (iv),
    .i_ifu_rsp_inst  (ri),
    .o_inst          (o_inst),
    .i_is_mem        (mem),
    .o_lsu_req_valid (o_lrv),
    .i_lsu_req_ready (lr),
    .i_lsu_rsp_valid (lv),
    .i_exu_reg_wen   (ew),
    .o_reg_wen       (o_rw),
    .o_pc_wen        (o_pc),
    .o_halt          (o_h),
    .o_halt_err      (o_he)
`ifdef CORE_SEQ_PERF_EN
    ,
    .o_perf_cycles   (perf_cyc),
    .o_perf_insts    (perf_ins)
`endif
  );

  core_seq_ctrl #(
    .TIMEOUT (TimeoutShort)
  ) dut_t (
    .i_clock         (clk),
    .i_reset         (t_rst),
    .o_ifu_req_valid (t_irv),
    .i_ifu_req_ready (1'b0),
    .i_ifu_rsp_valid (1'b0),
    .i_ifu_rsp_inst  (32'h0),
    .o_inst          (t_inst),
    .i_is_mem        (1'b0),
    .o_lsu_req_valid (t_lrv),
    .i_lsu_req_ready (1'b0),
    .i_lsu_rsp_valid (1'b0),
    .i_exu_reg_wen   (1'b0),
    .o_reg_wen       (t_rw),
    .o_pc_wen        (t_pc),
    .o_halt          (t_h),
    .o_halt_err      (t_he)
`ifdef CORE_SEQ_PERF_EN
    ,
    .o_perf_cycles   (t_perf_cyc),
    .o_perf_insts    (t_perf_ins)
`endif
  );

`ifndef CORE_SEQ_PERF_EN
  assign perf_cyc   = '0;
  assign perf_ins   = '0;
  assign t_perf_cyc = '0;
  assign t_perf_ins = '0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // expected strobe bundle order: {ifu_req_valid, lsu_req_valid, pc_wen, reg_wen, halt, halt_err}
  typedef struct {
    logic        chk;
    logic        rst, ir, iv;
    logic [31:0] ri;
    logic        mem, lr, lv, ew;
    logic [5:0]  e;
    logic [31:0] e_inst;
    logic        pchk;
    logic [63:0] e_pcyc, e_pins;
  } vec_t;

  function automatic vec_t mk(input logic chk, rst_v, ir_v, iv_v, input logic [31:0] ri_v,
                              input logic mem_v, lr_v, lv_v, ew_v, input logic [5:0] e,
                              input logic [31:0] ei);
    vec_t v;
    v.chk = chk; v.rst = rst_v; v.ir = ir_v; v.iv = iv_v; v.ri = ri_v;
    v.mem = mem_v; v.lr = lr_v; v.lv = lv_v; v.ew = ew_v; v.e = e; v.e_inst = ei;
    v.pchk = 1'b0; v.e_pcyc = '0; v.e_pins = '0;
    return v;
  endfunction

  // Called just after a rising edge: drive, sample at the falling edge, advance one cycle.
  task automatic apply_row(input vec_t v, input string name);
    rst = v.rst; ir = v.ir; iv = v.iv; ri = v.ri;
    mem = v.mem; lr = v.lr; lv = v.lv; ew = v.ew;
    @(negedge clk);
    if (v.chk) begin
      check({name, "/strobes"}, {58'd0, o_irv, o_lrv, o_pc, o_rw, o_h, o_he}, {58'd0, v.e});
      check({name, "/inst"}, {32'd0, o_inst}, {32'd0, v.e_inst});
`ifdef CORE_SEQ_PERF_EN
      if (v.pchk) begin
        check({name, "/perf_cycles"}, perf_cyc, v.e_pcyc);
        check({name, "/perf_insts"}, perf_ins, v.e_pins);
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: where the core is in its instruction (stage), whether the current
  // request has been accepted and a response is awaited, and how long it has waited.
  typedef enum int {MIdle, MFetch, MExec, MMem, MWb, MHalt} mstage_e;
  mstage_e     m_stage;
  logic        m_acc;
  int unsigned m_wait;
  logic [31:0] m_inst;
  logic        m_err;
  logic [63:0] m_cyc, m_ins;

  task automatic model_step(input logic rst_s, ir_s, iv_s, input logic [31:0] ri_s,
                            input logic mem_s, lr_s, lv_s);
    logic rdy, rsp, got;
    if (rst_s) begin
      m_stage = MIdle; m_acc = 1'b0; m_wait = 0; m_inst = '0; m_err = 1'b0;
      m_cyc = '0; m_ins = '0;
    end else begin
      if (m_stage != MHalt) m_cyc = m_cyc + 64'd1;
      if (m_stage == MWb)   m_ins = m_ins + 64'd1;
      case (m_stage)
        MIdle: m_stage = MFetch;
        MFetch, MMem: begin
          rdy = (m_stage == MFetch) ? ir_s : lr_s;
          rsp = (m_stage == MFetch) ? iv_s : lv_s;
          got = m_acc ? rsp : (rdy && rsp);
          m_wait++;
          if (m_wait >= TimeoutMain) begin
            m_stage = MHalt; m_err = 1'b1; m_acc = 1'b0; m_wait = 0;
          end else if (got) begin
            if (m_stage == MFetch) begin
              m_inst  = ri_s;
              m_stage = MExec;
            end else begin
              m_stage = MWb;
            end
            m_acc = 1'b0; m_wait = 0;
          end else if (!m_acc && rdy) begin
            m_acc = 1'b1;
          end
        end
        MExec: begin
          if (m_inst == Ebreak) m_stage = MHalt;
          else                  m_stage = mem_s ? MMem : MWb;
        end
        MWb:     m_stage = MFetch;
        default: ;
      endcase
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   fetch_cnt;
    logic halted;
    logic [31:0] r;

    rst = 1'b1; ir = 1'b0; iv = 1'b0; ri = '0; mem = 1'b0; lr = 1'b0; lv = 1'b0; ew = 1'b0;
    t_rst = 1'b1;

    // ---- watchdog: TIMEOUT=8, IFU never ready ----
    @(posedge clk); @(posedge clk); #1;
    t_rst = 1'b0;
    fetch_cnt = 0;
    halted = 1'b0;
    for (int c = 0; c < 40 && !halted; c++) begin
      @(negedge clk);
      if (t_h) halted = 1'b1;
      else if (t_irv) fetch_cnt++;
    end
    check("wdog/halt_reached", {63'd0, halted}, 64'd1);
    check("wdog/fetch_cycles", 64'(fetch_cnt), 64'd8);
    check("wdog/halt_err", {63'd0, t_he}, 64'd1);
    check("wdog/quiet", {61'd0, t_irv, t_pc, t_rw}, 64'd0);
    @(posedge clk); #1;

    // ---- directed vector table ----
    //            chk rst ir iv ri            mem lr lv ew exp        inst
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 32'h0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 32'h0));        // idle bubble
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 0, 6'b100000, 32'h0));        // fetch
    tbl.push_back(mk(1, 0, 1, 1, 32'h00500093, 0, 0, 0, 0, 6'b000000, 32'h0));        // iwait
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 1, 6'b000000, 32'h00500093)); // exec
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 1, 6'b001100, 32'h00500093)); // wb
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 0, 6'b100000, 32'h00500093));
    tbl.push_back(mk(1, 0, 1, 1, 32'h00500093, 0, 0, 0, 0, 6'b000000, 32'h00500093));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 1, 6'b000000, 32'h00500093));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 0, 1, 6'b001100, 32'h00500093)); // 4-cycle
    tbl.push_back(mk(1, 0, 1, 1, 32'h00a00113, 0, 0, 0, 0, 6'b100000, 32'h00500093)); // same-cycle
    tbl.push_back(mk(1, 0, 0, 1, 32'hffffffff, 0, 0, 0, 0, 6'b000000, 32'h00a00113)); // exec, stray rsp
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 6'b001000, 32'h00a00113)); // wb, no reg write
    tbl.push_back(mk(1, 0, 0, 1, 32'hdeadbeef, 0, 0, 0, 0, 6'b100000, 32'h00a00113)); // rsp w/o ready
    tbl.push_back(mk(1, 0, 1, 1, 32'h0000a083, 0, 0, 0, 0, 6'b100000, 32'h00a00113)); // lw
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 6'b000000, 32'h0000a083)); // exec -> mem
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 6'b010000, 32'h0000a083));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 6'b010000, 32'h0000a083)); // rsp w/o ready
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 6'b010000, 32'h0000a083));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 0, 0, 6'b010000, 32'h0000a083)); // accepted
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 6'b000000, 32'h0000a083)); // mwait
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 1, 1, 6'b000000, 32'h0000a083));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 6'b001100, 32'h0000a083)); // wb
    tbl.push_back(mk(1, 0, 1, 1, 32'h00102023, 0, 0, 0, 0, 6'b100000, 32'h0000a083)); // sw
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0, 1, 0, 6'b000000, 32'h00102023));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 1, 0, 6'b010000, 32'h00102023)); // mwait skip
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 6'b001000, 32'h00102023));
    tbl.push_back(mk(1, 0, 1, 1, Ebreak,       0, 0, 0, 0, 6'b100000, 32'h00102023)); // ebreak
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 6'b000000, Ebreak));
    tbl.push_back(mk(1, 0, 1, 1, 32'h0,        1, 1, 1, 1, 6'b000010, Ebreak));       // halted
    foreach (tbl[i]) apply_row(tbl[i], $sformatf("vec%0d", i));

    // ---- halt is absorbing and quiet ----
    for (int c = 0; c < 20; c++) begin
      v = mk(1, 0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 6'b000010, Ebreak);
      apply_row(v, $sformatf("halt_quiet%0d", c));
    end

    // ---- reset while waiting for an LSU response, then a late response ----
    apply_row(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000010, Ebreak), "rst_mw0");
    apply_row(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 32'h0),  "rst_mw1");
    apply_row(mk(1, 0, 1, 1, 32'h0000a083, 0, 0, 0, 0, 6'b100000, 32'h0),  "rst_mw2");
    apply_row(mk(1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 6'b000000, 32'h0000a083), "rst_mw3");
    apply_row(mk(1, 0, 0, 0, 32'h0,        0, 1, 0, 0, 6'b010000, 32'h0000a083), "rst_mw4");
    apply_row(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 6'b000000, 32'h0000a083), "rst_mw5");
    v = mk(1, 0, 0, 0, 32'h0, 0, 0, 1, 1, 6'b000000, 32'h0);
    v.pchk = 1'b1; v.e_pcyc = 64'd0; v.e_pins = 64'd0;
    apply_row(v, "rst_mw6");
    v = mk(1, 0, 0, 0, 32'h0, 0, 0, 1, 1, 6'b100000, 32'h0);
    v.pchk = 1'b1; v.e_pcyc = 64'd1; v.e_pins = 64'd0;
    apply_row(v, "rst_mw7");
    apply_row(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 6'b100000, 32'h0),  "rst_mw8");

    // ---- randomized traffic against the reference model ----
    for (int c = 0; c < NumRandom; c++) begin
      if (c == 0) rst = 1'b1;
      else if (m_stage == MHalt) rst = ($urandom_range(0, 7) == 0);
      else rst = ($urandom_range(0, 299) == 0);
      ir = 1'($urandom); iv = 1'($urandom);
      r = $urandom_range(0, 39);
      if (r == 0)      ri = Ebreak;
      else if (r < 14) ri = 32'h00500093;
      else if (r < 27) ri = 32'h0000a083;
      else             ri = $urandom;
      mem = 1'($urandom); lr = 1'($urandom); lv = 1'($urandom); ew = 1'($urandom);
      @(negedge clk);
      if (c != 0) begin
        check($sformatf("rand%0d/strobes", c),
              {58'd0, o_irv, o_lrv, o_pc, o_rw, o_h, o_he},
              {58'd0, (m_stage == MFetch) && !m_acc, (m_stage == MMem) && !m_acc,
               m_stage == MWb, (m_stage == MWb) && ew, m_stage == MHalt, m_err});
        check($sformatf("rand%0d/inst", c), {32'd0, o_inst}, {32'd0, m_inst});
`ifdef CORE_SEQ_PERF_EN
        check($sformatf("rand%0d/perf_cycles", c), perf_cyc, m_cyc);
        check($sformatf("rand%0d/perf_insts", c), perf_ins, m_ins);
`endif
      end
      @(posedge clk);
      model_step(rst, ir, iv, ri, mem, lr, lv);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
